div_ctrl: RTL and testbench

//  Sequences a multi-cycle radix-2 restoring divider for DIV/DIVU in Execute.

---
 rtl/div_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - radix-2 restoring divider sequencer for DIV/DIVU in Execute
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   startE, signedE   divide resident in Execute; 1 = DIV, 0 = DIVU
//   srcaE, srcbE      dividend / divisor after forwarding
//   annulE            cancel any in-flight divide (flush/exception)
//   div_stall         stall F/D/E this cycle
//   busy              sequencer not idle
//   result_valid      one-cycle pulse; hi_o/lo_o carry the new result
//   hi_o, lo_o        remainder / quotient
module div_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startE,
   input  logic              signedE,
   input  logic [DATA_W-1:0] srcaE,
   input  logic [DATA_W-1:0] srcbE,
   input  logic              annulE,
   output logic              div_stall,
   output logic              busy,
   output logic              result_valid,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   dvd_q;     // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0]   dvs_q;
   logic [DATA_W-1:0]   rem_q;
   logic                neg_quo_q;
   logic                neg_rem_q;
   logic [DATA_W-1:0]   hi_q, lo_q;

   logic                accept;
   logic                div_zero;
   logic                sign_a, sign_b;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     shifted;
   logic                ge;
   logic [DATA_W-1:0]   rem_nxt, quo_nxt;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   assign sign_a   = signedE & srcaE[DATA_W-1];
   assign sign_b   = signedE & srcbE[DATA_W-1];
   assign mag_a    = sign_a ? -srcaE : srcaE;
   assign mag_b    = sign_b ? -srcbE : srcbE;
   assign div_zero = (srcbE == '0);

   // rst gates acceptance so div_stall reads 0 while reset is held.
   assign accept = !rst && (state_q == S_IDLE) && startE && !annulE;

   // One restoring step. The partial remainder is always below the divisor,
   // so the DATA_W+1 bit shifted value cannot overflow the compare, and when
   // the subtraction is taken its result fits back into DATA_W bits.
   assign shifted = {rem_q, dvd_q[DATA_W-1]};
   assign ge      = (shifted >= {1'b0, dvs_q});
   assign rem_nxt = ge ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
   assign quo_nxt = {dvd_q[DATA_W-2:0], ge};

   // Results are corrected on the final CALC step and registered on entry to
   // DONE, so hi_o/lo_o already hold them in the result_valid cycle.
   assign quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
   assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (annulE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (startE) state_d = div_zero ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;   // startE still shows the same instruction
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      div_stall    = accept || (state_q == S_CALC);
      busy         = (state_q != S_IDLE);
      result_valid = (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (accept) begin
         cnt_q     <= '0;
         dvd_q     <= mag_a;
         dvs_q     <= mag_b;
         rem_q     <= '0;
         neg_quo_q <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
         if (div_zero) begin
            lo_q <= '1;
            hi_q <= srcaE;
         end
      end else if ((state_q == S_CALC) && !annulE) begin
         cnt_q <= cnt_q + CNT_W'(1);
         dvd_q <= quo_nxt;
         rem_q <= rem_nxt;
         if (cnt_q == LAST_CNT) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed table-driven bench for div_ctrl
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        startE;
   logic        signedE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        annulE;
   logic        div_stall;
   logic        busy;
   logic        result_valid;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      int          stalls;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .startE       (startE),
      .signedE      (signedE),
      .srcaE        (srcaE),
      .srcbE        (srcbE),
      .annulE       (annulE),
      .div_stall    (div_stall),
      .busy         (busy),
      .result_valid (result_valid),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Assumes startE/operands are already driven for the current (IDLE) cycle.
   task automatic finish_div(input string name, input logic [31:0] elo,
                             input logic [31:0] ehi, input int estall);
      int          stalls = 0;
      logic        seen   = 1'b0;
      logic        vstall = 1'b1;
      logic [31:0] glo    = '0;
      logic [31:0] ghi    = '0;
      for (int c = 0; c < 80 && !seen; c++) begin
         @(negedge clk);
         if (result_valid) begin
            seen   = 1'b1;
            glo    = lo_o;
            ghi    = hi_o;
            vstall = div_stall;
         end else if (div_stall) begin
            stalls++;
         end
      end
      check({name, "_valid"}, {31'd0, seen}, 32'd1);
      check({name, "_stalls"}, stalls, estall);
      check({name, "_done_stall"}, {31'd0, vstall}, 32'd0);
      check({name, "_lo"}, glo, elo);
      check({name, "_hi"}, ghi, ehi);
      @(posedge clk); #1;
      startE = 1'b0;
      @(negedge clk);
      check({name, "_no_restart"}, {30'd0, busy, result_valid}, 32'd0);
   endtask

   task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input int estall);
      @(posedge clk); #1;
      startE  = 1'b1;
      signedE = sgn;
      srcaE   = a;
      srcbE   = b;
      finish_div(name, elo, ehi, estall);
   endtask

   initial begin
      int pulses;

      vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33};
      vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33};
      vecs[4]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         33};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         33};
      vecs[7]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33};
      vecs[8]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
      vecs[9]  = '{1'b1, 32'd3,         32'd0,         32'hFFFF_FFFF, 32'd3,         1};
      vecs[10] = '{1'b0, 32'h1234_5678, 32'h100,       32'h0012_3456, 32'h78,        33};
      vecs[11] = '{1'b0, 32'd7,         32'd9,         32'd0,         32'd7,         33};

      rst = 1'b1; startE = 1'b0; signedE = 1'b0; srcaE = '0; srcbE = '0; annulE = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'd0, div_stall}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         run_div($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                 vecs[i].lo, vecs[i].hi, vecs[i].stalls);

      // Annul while IDLE with startE: nothing starts.
      @(posedge clk); #1;
      startE = 1'b1; annulE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
      @(negedge clk);
      check("idle_annul_stall", {31'd0, div_stall}, 32'd0);
      @(posedge clk); #1;
      startE = 1'b0; annulE = 1'b0;
      @(negedge clk);
      check("idle_annul_busy", {31'd0, busy}, 32'd0);

      // Annul in CALC cycle 10; previous result (7/9) must survive.
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
      repeat (10) @(posedge clk);
      #1 annulE = 1'b1;
      @(negedge clk);
      check("annul_cycle_stall", {31'd0, div_stall}, 32'd1);
      @(posedge clk); #1;
      annulE = 1'b0; startE = 1'b0;
      @(negedge clk);
      check("annul_next_stall", {31'd0, div_stall}, 32'd0);
      check("annul_next_busy", {31'd0, busy}, 32'd0);
      check("annul_lo_kept", lo_o, 32'd0);
      check("annul_hi_kept", hi_o, 32'd7);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (result_valid) pulses++;
      end
      check("annul_no_valid", pulses, 0);
      run_div("after_annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // Reset in CALC cycle 5 with startE held; the divide reruns from scratch.
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_stall", {31'd0, div_stall}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_valid", {31'd0, result_valid}, 32'd0);
      check("midrst_lo", lo_o, 32'd0);
      check("midrst_hi", hi_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      finish_div("rerun", 32'd14, 32'd2, 33);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
